// File: rtl/burst_ram_arbiter.sv
// burst_ram_arbiter
//   Shares one burst-RAM (PSRAM controller) command port between two burst
//   masters. It grants one client at a time and puts that client's command on
//   the br_ bus. It steers the granted client's write beats to the RAM and
//   routes read beats back to that client only. It also spaces commands by
//   at least COMMAND_DELAY_INTERVAL+1 cycles.
//
//   Optional build macro: BURST_ARBITER_FIXED_PRIORITY_EN
//     defined   : client 0 always wins a simultaneous request
//     undefined : round-robin tie-break using last_served
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | no burst in flight; may issue when a request is pending and
//         | the interval counter has reached 0
//   WRITE | streaming the owner's write beats 1..BURST_BEATS-1 to br_wr_data
//   READ  | counting read-valid beats routed to the owner

module burst_ram_arbiter #(
  parameter int RAM_DEPTH_BITWIDTH     = 21,
  parameter int BURST_BEATS            = 4,
  parameter int COMMAND_DELAY_INTERVAL = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,

  input  logic                          c0_req,
  input  logic                          c0_cmd,
  input  logic [RAM_DEPTH_BITWIDTH-1:0] c0_addr,
  input  logic [63:0]                   c0_wr_data,
  output logic                          c0_ack,
  output logic [63:0]                   c0_rd_data,
  output logic                          c0_rd_data_valid,

  input  logic                          c1_req,
  input  logic                          c1_cmd,
  input  logic [RAM_DEPTH_BITWIDTH-1:0] c1_addr,
  input  logic [63:0]                   c1_wr_data,
  output logic                          c1_ack,
  output logic [63:0]                   c1_rd_data,
  output logic                          c1_rd_data_valid,

  output logic                          br_cmd,
  output logic                          br_cmd_en,
  output logic [RAM_DEPTH_BITWIDTH-1:0] br_addr,
  output logic [63:0]                   br_wr_data,
  output logic [7:0]                    br_data_mask,
  input  logic [63:0]                   br_rd_data,
  input  logic                          br_rd_data_valid
);

  // A single-beat burst still needs a 1-bit counter so the vectors stay legal.
  localparam int BEAT_W = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
  localparam logic [BEAT_W-1:0] RD_LAST = BEAT_W'(BURST_BEATS - 1);
  // In WRITE the beat being captured is beat_q+1, so the last capture happens
  // when beat_q reaches BURST_BEATS-2.
  localparam logic [BEAT_W-1:0] WR_LAST = (BURST_BEATS > 1) ? BEAT_W'(BURST_BEATS - 2) : '0;
  // Interval counter is 6 bits wide; intervals above 63 are truncated.
  localparam logic [5:0] IVL_LOAD = 6'(COMMAND_DELAY_INTERVAL);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  state_t                  state_q, state_nxt;
  logic                    owner_q, owner_nxt;
  logic                    last_served_q, last_served_nxt;
  logic [BEAT_W-1:0]       beat_q, beat_nxt;
  logic [5:0]              ivl_q, ivl_nxt;

  logic                    cmd_nxt;
  logic                    cmd_en_nxt;
  logic [RAM_DEPTH_BITWIDTH-1:0] addr_nxt;
  logic [63:0]             wr_data_nxt;
  logic                    ack0_nxt;
  logic                    ack1_nxt;

  logic                    any_req;
  logic                    issue;
  logic                    pick;
  logic                    win_cmd;
  logic [RAM_DEPTH_BITWIDTH-1:0] win_addr;
  logic [63:0]             win_wr_data;
  logic [63:0]             own_wr_data;

  assign any_req = c0_req | c1_req;
  assign issue   = any_req && (ivl_q == 6'd0);

`ifdef BURST_ARBITER_FIXED_PRIORITY_EN
  // Client 0 wins whenever it is requesting.
  assign pick = c0_req ? 1'b0 : 1'b1;
`else
  // On a tie the client that was not served last wins; otherwise the sole requester.
  assign pick = (c0_req && c1_req) ? ~last_served_q : (c0_req ? 1'b0 : 1'b1);
`endif

  assign win_cmd     = pick ? c1_cmd     : c0_cmd;
  assign win_addr    = pick ? c1_addr    : c0_addr;
  assign win_wr_data = pick ? c1_wr_data : c0_wr_data;
  assign own_wr_data = owner_q ? c1_wr_data : c0_wr_data;

  assign br_data_mask = 8'h00;

  // Read data is a zero-latency pass-through; valid only reaches the owner during READ.
  assign c0_rd_data       = br_rd_data;
  assign c1_rd_data       = br_rd_data;
  assign c0_rd_data_valid = br_rd_data_valid && (state_q == READ) && !owner_q;
  assign c1_rd_data_valid = br_rd_data_valid && (state_q == READ) &&  owner_q;

  // Next-state, counter and registered-output decode.
  always_comb begin
    state_nxt       = state_q;
    owner_nxt       = owner_q;
    last_served_nxt = last_served_q;
    beat_nxt        = beat_q;
    ivl_nxt         = (ivl_q != 6'd0) ? (ivl_q - 6'd1) : 6'd0;
    cmd_nxt         = br_cmd;
    cmd_en_nxt      = 1'b0;
    addr_nxt        = br_addr;
    wr_data_nxt     = br_wr_data;
    ack0_nxt        = 1'b0;
    ack1_nxt        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (issue) begin
          cmd_nxt         = win_cmd;
          cmd_en_nxt      = 1'b1;
          addr_nxt        = win_addr;
          wr_data_nxt     = win_wr_data;
          ack0_nxt        = ~pick;
          ack1_nxt        = pick;
          ivl_nxt         = IVL_LOAD;
          owner_nxt       = pick;
          last_served_nxt = pick;
          beat_nxt        = '0;
          if (win_cmd) begin
            // A one-beat write is complete once beat 0 is captured.
            state_nxt = (BURST_BEATS > 1) ? WRITE : IDLE;
          end else begin
            state_nxt = READ;
          end
        end
      end

      WRITE: begin
        wr_data_nxt = own_wr_data;
        beat_nxt    = beat_q + 1'b1;
        if (beat_q == WR_LAST) begin
          state_nxt = IDLE;
          beat_nxt  = '0;
        end
      end

      READ: begin
        if (br_rd_data_valid) begin
          beat_nxt = beat_q + 1'b1;
          if (beat_q == RD_LAST) begin
            state_nxt = IDLE;
            beat_nxt  = '0;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
        beat_nxt  = '0;
      end
    endcase
  end

  // State, counters and registered br_/ack outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      owner_q       <= 1'b0;
      last_served_q <= 1'b1;
      beat_q        <= '0;
      ivl_q         <= 6'd0;
      br_cmd        <= 1'b0;
      br_cmd_en     <= 1'b0;
      br_addr       <= '0;
      br_wr_data    <= 64'd0;
      c0_ack        <= 1'b0;
      c1_ack        <= 1'b0;
    end else begin
      state_q       <= state_nxt;
      owner_q       <= owner_nxt;
      last_served_q <= last_served_nxt;
      beat_q        <= beat_nxt;
      ivl_q         <= ivl_nxt;
      br_cmd        <= cmd_nxt;
      br_cmd_en     <= cmd_en_nxt;
      br_addr       <= addr_nxt;
      br_wr_data    <= wr_data_nxt;
      c0_ack        <= ack0_nxt;
      c1_ack        <= ack1_nxt;
    end
  end

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// Testbench for burst_ram_arbiter: a cycle table covering reset, a c0 read,
// a stray valid in IDLE, a pending c1 write held off by the interval counter,
// followed by hand-written tie, dropped-request and mid-burst-reset sequences.

module tb_burst_ram_arbiter;

  localparam int AW  = 21;
  localparam int CDI = 16;

  logic            clk;
  logic            rst_n;
  logic            c0_req, c0_cmd, c1_req, c1_cmd;
  logic [AW-1:0]   c0_addr, c1_addr;
  logic [63:0]     c0_wr_data, c1_wr_data;
  logic            c0_ack, c1_ack;
  logic [63:0]     c0_rd_data, c1_rd_data;
  logic            c0_rd_data_valid, c1_rd_data_valid;
  logic            br_cmd, br_cmd_en;
  logic [AW-1:0]   br_addr;
  logic [63:0]     br_wr_data;
  logic [7:0]      br_data_mask;
  logic [63:0]     br_rd_data;
  logic            br_rd_data_valid;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  burst_ram_arbiter #(
    .RAM_DEPTH_BITWIDTH(AW),
    .BURST_BEATS(4),
    .COMMAND_DELAY_INTERVAL(CDI)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .c0_req(c0_req), .c0_cmd(c0_cmd), .c0_addr(c0_addr), .c0_wr_data(c0_wr_data),
    .c0_ack(c0_ack), .c0_rd_data(c0_rd_data), .c0_rd_data_valid(c0_rd_data_valid),
    .c1_req(c1_req), .c1_cmd(c1_cmd), .c1_addr(c1_addr), .c1_wr_data(c1_wr_data),
    .c1_ack(c1_ack), .c1_rd_data(c1_rd_data), .c1_rd_data_valid(c1_rd_data_valid),
    .br_cmd(br_cmd), .br_cmd_en(br_cmd_en), .br_addr(br_addr), .br_wr_data(br_wr_data),
    .br_data_mask(br_data_mask), .br_rd_data(br_rd_data), .br_rd_data_valid(br_rd_data_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic          rst_n;
    logic          r0, m0;
    logic [AW-1:0] a0;
    logic [63:0]   w0;
    logic          r1, m1;
    logic [AW-1:0] a1;
    logic [63:0]   w1;
    logic [63:0]   rdd;
    logic          rdv;
    logic          e_ack0, e_ack1, e_en, e_cmd;
    logic [AW-1:0] e_addr;
    logic [63:0]   e_wd;
    logic          e_v0, e_v1;
  } vec_t;

  vec_t tbl[$];
  vec_t v;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t x);
    rst_n            = x.rst_n;
    c0_req           = x.r0;  c0_cmd = x.m0; c0_addr = x.a0; c0_wr_data = x.w0;
    c1_req           = x.r1;  c1_cmd = x.m1; c1_addr = x.a1; c1_wr_data = x.w1;
    br_rd_data       = x.rdd;
    br_rd_data_valid = x.rdv;
  endtask

  task automatic wait_ack(input int budget, output int who, output int at);
    who = -1;
    at  = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (c0_ack || c1_ack) begin
        who = c1_ack ? 1 : 0;
        at  = cyc;
        break;
      end
    end
    n_cmp++;
    if (who < 0) begin
      n_bad++;
      $display("FAIL ack_timeout: neither client acknowledged within %0d cycles, required one", budget);
    end else begin
      chk("ack_exclusive", {63'd0, c0_ack & c1_ack}, 64'd0);
      chk("ack_with_cmd_en", {63'd0, br_cmd_en}, 64'd1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int who, at, prev_at, pulses, req_cyc;
    int exp_who;
    string nm;

    v = '{default: '0};
    apply(v);

    // ---- cycle table ------------------------------------------------------
    v.rst_n = 1'b0; tbl.push_back(v); tbl.push_back(v);          // 0,1 reset
    v.rst_n = 1'b1; tbl.push_back(v);                            // 2 idle
    v.r0 = 1'b1; v.a0 = 21'h000100; tbl.push_back(v);            // 3 c0 read req
    v.e_ack0 = 1'b1; v.e_en = 1'b1; v.e_addr = 21'h000100;
    tbl.push_back(v);                                            // 4 ack
    v.r0 = 1'b0; v.e_ack0 = 1'b0; v.e_en = 1'b0; tbl.push_back(v); // 5
    v.rdv = 1'b1; v.rdd = 64'h1111111111111111; v.e_v0 = 1'b1; tbl.push_back(v); // 6
    v.rdd = 64'h2222222222222222; tbl.push_back(v);              // 7
    v.rdv = 1'b0; v.rdd = 64'hDEADBEEFDEADBEEF; v.e_v0 = 1'b0; tbl.push_back(v); // 8 gap
    v.rdv = 1'b1; v.rdd = 64'h3333333333333333; v.e_v0 = 1'b1; tbl.push_back(v); // 9
    v.rdd = 64'h4444444444444444; tbl.push_back(v);              // 10 last beat
    v.rdd = 64'h5555555555555555; v.e_v0 = 1'b0; tbl.push_back(v); // 11 stray in IDLE
    v.rdv = 1'b0; v.rdd = 64'd0;
    v.r1 = 1'b1; v.m1 = 1'b1; v.a1 = 21'h000200; v.w1 = 64'hA0;
    for (int i = 12; i <= 20; i++) tbl.push_back(v);             // 12..20 held off
    v.w1 = 64'hA1; v.e_ack1 = 1'b1; v.e_en = 1'b1; v.e_cmd = 1'b1;
    v.e_addr = 21'h000200; v.e_wd = 64'hA0; tbl.push_back(v);    // 21 ack
    v.r1 = 1'b0; v.w1 = 64'hA2; v.e_ack1 = 1'b0; v.e_en = 1'b0; v.e_wd = 64'hA1;
    v.rdv = 1'b1; v.rdd = 64'h6666666666666666; tbl.push_back(v); // 22 stray in WRITE
    v.rdv = 1'b0; v.rdd = 64'd0; v.w1 = 64'hA3; v.e_wd = 64'hA2; tbl.push_back(v); // 23
    v.w1 = 64'hFFFFFFFFFFFFFFFF; v.e_wd = 64'hA3; tbl.push_back(v); // 24
    tbl.push_back(v);                                            // 25 held

    foreach (tbl[i]) begin
      @(posedge clk); #1;
      apply(tbl[i]);
      @(negedge clk);
      nm = $sformatf("row%0d", i);
      chk({nm, " c0_ack"},   {63'd0, c0_ack},           {63'd0, tbl[i].e_ack0});
      chk({nm, " c1_ack"},   {63'd0, c1_ack},           {63'd0, tbl[i].e_ack1});
      chk({nm, " cmd_en"},   {63'd0, br_cmd_en},        {63'd0, tbl[i].e_en});
      chk({nm, " br_cmd"},   {63'd0, br_cmd},           {63'd0, tbl[i].e_cmd});
      chk({nm, " br_addr"},  64'(br_addr),              64'(tbl[i].e_addr));
      chk({nm, " br_wdata"}, br_wr_data,                tbl[i].e_wd);
      chk({nm, " c0_valid"}, {63'd0, c0_rd_data_valid}, {63'd0, tbl[i].e_v0});
      chk({nm, " c1_valid"}, {63'd0, c1_rd_data_valid}, {63'd0, tbl[i].e_v1});
      chk({nm, " c0_rdata"}, c0_rd_data,                tbl[i].rdd);
      chk({nm, " c1_rdata"}, c1_rd_data,                tbl[i].rdd);
      chk({nm, " mask"},     64'(br_data_mask),         64'd0);
    end

    // ---- simultaneous read requests: arbitration order and spacing -------
    @(posedge clk); #1;
    c0_req = 1'b1; c0_cmd = 1'b0; c0_addr = 21'h000300;
    c1_req = 1'b1; c1_cmd = 1'b0; c1_addr = 21'h000340;
    c1_wr_data = 64'd0;
    prev_at = 0;
    for (int g = 0; g < 4; g++) begin
      wait_ack(60, who, at);
`ifdef BURST_ARBITER_FIXED_PRIORITY_EN
      exp_who = 0;
`else
      exp_who = g % 2;
`endif
      chk($sformatf("tie_grant%0d", g), 64'(who), 64'(exp_who));
      chk($sformatf("tie_addr%0d", g), 64'(br_addr), (who == 1) ? 64'h340 : 64'h300);
      chk($sformatf("tie_cmd%0d", g), {63'd0, br_cmd}, 64'd0);
      if (g > 0) begin
        n_cmp++;
        if (at - prev_at < CDI + 1) begin
          n_bad++;
          $display("FAIL gap%0d: got %0d cycles between commands, required >= %0d",
                   g, at - prev_at, CDI + 1);
        end
      end
      prev_at = at;
      @(posedge clk); #1;
      if (who == 1) c1_req = 1'b0; else c0_req = 1'b0;
      for (int b = 0; b < 4; b++) begin
        if (b > 0) begin @(posedge clk); #1; end
        br_rd_data_valid = 1'b1;
        br_rd_data = 64'hC0DE000000000000 | 64'(g * 4 + b);
        @(negedge clk);
        chk($sformatf("tie%0d_beat%0d own_valid", g, b),
            {63'd0, (who == 1) ? c1_rd_data_valid : c0_rd_data_valid}, 64'd1);
        chk($sformatf("tie%0d_beat%0d other_valid", g, b),
            {63'd0, (who == 1) ? c0_rd_data_valid : c1_rd_data_valid}, 64'd0);
        chk($sformatf("tie%0d_beat%0d data", g, b),
            (who == 1) ? c1_rd_data : c0_rd_data, 64'hC0DE000000000000 | 64'(g * 4 + b));
      end
      @(posedge clk); #1;
      br_rd_data_valid = 1'b0;
      if (who == 1) c1_req = 1'b1; else c0_req = 1'b1;
    end

    // ---- pending requests dropped before ack are discarded ---------------
    c0_req = 1'b0; c1_req = 1'b0;
    pulses = 0;
    repeat (30) begin
      @(negedge clk);
      if (br_cmd_en || c0_ack || c1_ack) pulses++;
    end
    chk("dropped_req_no_issue", 64'(pulses), 64'd0);

    // ---- reset between read beats 2 and 3 --------------------------------
    @(posedge clk); #1;
    c0_req = 1'b1; c0_cmd = 1'b0; c0_addr = 21'h000500;
    wait_ack(5, who, at);
    chk("rst_test_grant", 64'(who), 64'd0);
    @(posedge clk); #1;
    c0_req = 1'b0;
    br_rd_data_valid = 1'b1; br_rd_data = 64'hB1;
    @(negedge clk);
    chk("rst_test_beat1", {63'd0, c0_rd_data_valid}, 64'd1);
    @(posedge clk); #1;
    br_rd_data = 64'hB2;
    @(negedge clk);
    chk("rst_test_beat2", {63'd0, c0_rd_data_valid}, 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b0; br_rd_data_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; br_rd_data_valid = 1'b1; br_rd_data = 64'hB3;
    @(negedge clk);
    chk("post_rst c0_ack",   {63'd0, c0_ack},           64'd0);
    chk("post_rst c1_ack",   {63'd0, c1_ack},           64'd0);
    chk("post_rst cmd_en",   {63'd0, br_cmd_en},        64'd0);
    chk("post_rst br_cmd",   {63'd0, br_cmd},           64'd0);
    chk("post_rst br_addr",  64'(br_addr),              64'd0);
    chk("post_rst br_wdata", br_wr_data,                64'd0);
    chk("post_rst c0_valid", {63'd0, c0_rd_data_valid}, 64'd0);
    chk("post_rst c1_valid", {63'd0, c1_rd_data_valid}, 64'd0);
    @(posedge clk); #1;
    br_rd_data = 64'hB4;
    @(negedge clk);
    chk("post_rst beat4 c0_valid", {63'd0, c0_rd_data_valid}, 64'd0);

    // ---- fresh write after reset issues with one-cycle latency -----------
    @(posedge clk); #1;
    br_rd_data_valid = 1'b0; br_rd_data = 64'd0;
    c1_req = 1'b1; c1_cmd = 1'b1; c1_addr = 21'h000600; c1_wr_data = 64'hB0B0;
    req_cyc = cyc;
    @(negedge clk);
    chk("wr_req_cycle ack", {63'd0, c1_ack}, 64'd0);
    @(posedge clk); #1;
    c1_wr_data = 64'hB1B1;
    @(negedge clk);
    chk("wr_latency", 64'(cyc - req_cyc), 64'd1);
    chk("wr_ack",     {63'd0, c1_ack},    64'd1);
    chk("wr_c0_ack",  {63'd0, c0_ack},    64'd0);
    chk("wr_cmd_en",  {63'd0, br_cmd_en}, 64'd1);
    chk("wr_cmd",     {63'd0, br_cmd},    64'd1);
    chk("wr_addr",    64'(br_addr),       64'h600);
    chk("wr_beat0",   br_wr_data,         64'hB0B0);
    @(posedge clk); #1;
    c1_req = 1'b0; c1_wr_data = 64'hB2B2;
    @(negedge clk);
    chk("wr_ack_pulse", {63'd0, c1_ack},    64'd0);
    chk("wr_en_pulse",  {63'd0, br_cmd_en}, 64'd0);
    chk("wr_beat1",     br_wr_data,         64'hB1B1);
    @(posedge clk); #1;
    c1_wr_data = 64'hB3B3;
    @(negedge clk);
    chk("wr_beat2", br_wr_data, 64'hB2B2);
    @(posedge clk); #1;
    c1_wr_data = 64'h0;
    @(negedge clk);
    chk("wr_beat3", br_wr_data, 64'hB3B3);
    @(posedge clk); #1;
    @(negedge clk);
    chk("wr_hold_after_burst", br_wr_data, 64'hB3B3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
